// File: rtl/threshold_pipe.sv
// threshold_pipe: adaptive-threshold engine.
// Raster-scans the image ROM and the local-mean threshold ROM in lock-step,
// one pixel per clock. Each pixel is compared against (threshold - C), and
// the result is shaped by one of four modes and streamed to the result
// memory with a write strobe. Mode and C are captured at start and held
// for the whole frame.
//
// Pipeline (k = start edge, p = raster index):
//   edge k+p   : read address p driven
//   edge k+p+1 : ROM data for p valid; stage-1 tags (valid, col, row) captured
//   edge k+p+2 : result for p registered together with its col/row and wren

module threshold_pipe #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int PIXEL_BITS  = 8,
    parameter int C_BITS      = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    input  logic [1:0]             iMode,
    input  logic [C_BITS-1:0]      iC,
    output logic [WIDTH_BITS-1:0]  oReadCol,
    output logic [HEIGHT_BITS-1:0] oReadRow,
    input  logic [PIXEL_BITS-1:0]  iImageData,
    input  logic [PIXEL_BITS-1:0]  iThresholdData,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [PIXEL_BITS-1:0]  oResultData,
    output logic                   oResultBit,
    output logic                   oResultWren,
    output logic                   busy,
    output logic                   finished
);

    // Wide enough that thr - C never wraps for any thr / C combination.
    localparam int EFF_BITS = PIXEL_BITS + C_BITS + 1;

    localparam logic [WIDTH_BITS-1:0]  COL_LAST = {WIDTH_BITS{1'b1}};
    localparam logic [HEIGHT_BITS-1:0] ROW_LAST = {HEIGHT_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_BINARY   = 2'd0,
        MODE_INVERTED = 2'd1,
        MODE_TOZERO   = 2'd2,
        MODE_TRUNCATE = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Effective threshold: thr zero-extended minus C sign-extended.
    function automatic logic signed [EFF_BITS-1:0] eff_threshold(
        input logic [PIXEL_BITS-1:0] thr,
        input logic [C_BITS-1:0]     c
    );
        logic signed [EFF_BITS-1:0] thr_ext;
        logic signed [EFF_BITS-1:0] c_ext;
        thr_ext = signed'({{(C_BITS + 1){1'b0}}, thr});
        c_ext   = signed'({{(PIXEL_BITS + 1){c[C_BITS-1]}}, c});
        return thr_ext - c_ext;
    endfunction

    // Strict compare of the zero-extended pixel against the effective threshold.
    function automatic logic pixel_passes(
        input logic [PIXEL_BITS-1:0]     pix,
        input logic signed [EFF_BITS-1:0] eff
    );
        logic signed [EFF_BITS-1:0] pix_ext;
        pix_ext = signed'({{(C_BITS + 1){1'b0}}, pix});
        return (pix_ext > eff);
    endfunction

    // Saturate a signed effective threshold into the pixel range.
    function automatic logic [PIXEL_BITS-1:0] clamp_pixel(
        input logic signed [EFF_BITS-1:0] v
    );
        logic signed [EFF_BITS-1:0] max_v;
        logic [PIXEL_BITS-1:0]      res;
        max_v = signed'({{(C_BITS + 1){1'b0}}, {PIXEL_BITS{1'b1}}});
        if (v[EFF_BITS-1]) begin
            res = {PIXEL_BITS{1'b0}};
        end else if (v > max_v) begin
            res = {PIXEL_BITS{1'b1}};
        end else begin
            res = v[PIXEL_BITS-1:0];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Control: sequencer, address counters, frame configuration
    // ------------------------------------------------------------------

    state_t                   state_q,    state_d;
    logic [WIDTH_BITS-1:0]    col_q,      col_d;
    logic [HEIGHT_BITS-1:0]   row_q,      row_d;
    logic                     drain_q,    drain_d;
    mode_t                    mode_q,     mode_d;
    logic [C_BITS-1:0]        c_q,        c_d;
    logic                     busy_q,     busy_d;
    logic                     finished_q, finished_d;

    // Next-state, scan-address and frame-configuration logic.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (iStart) begin
                    state_d = ST_RUN;
                    col_d   = {WIDTH_BITS{1'b0}};
                    row_d   = {HEIGHT_BITS{1'b0}};
                    mode_d  = mode_t'(iMode);
                    c_d     = iC;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                // The last address stays on the bus while the pipeline drains.
                if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else if (col_q == COL_LAST) begin
                    col_d = {WIDTH_BITS{1'b0}};
                    row_d = row_q + HEIGHT_BITS'(1);
                end else begin
                    col_d = col_q + WIDTH_BITS'(1);
                end
            end
            ST_DRAIN: begin
                // Two cycles: let the last pixel pass both pipeline stages.
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        finished_d = (state_d == ST_DONE);
    end

    // Sequencer registers with their registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            col_q      <= {WIDTH_BITS{1'b0}};
            row_q      <= {HEIGHT_BITS{1'b0}};
            drain_q    <= 1'b0;
            mode_q     <= MODE_BINARY;
            c_q        <= {C_BITS{1'b0}};
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            mode_q     <= mode_d;
            c_q        <= c_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: tag the address whose ROM data arrives next cycle
    // ------------------------------------------------------------------

    logic                   valid1_q, valid1_d;
    logic [WIDTH_BITS-1:0]  col1_q,   col1_d;
    logic [HEIGHT_BITS-1:0] row1_q,   row1_d;

    // An address is only a real pixel request while scanning.
    always_comb begin
        valid1_d = (state_q == ST_RUN);
        col1_d   = col_q;
        row1_d   = row_q;
    end

    // Stage-1 tag registers, aligned with the ROM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid1_q <= 1'b0;
            col1_q   <= {WIDTH_BITS{1'b0}};
            row1_q   <= {HEIGHT_BITS{1'b0}};
        end else begin
            valid1_q <= valid1_d;
            col1_q   <= col1_d;
            row1_q   <= row1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: threshold, mode shaping and result registers
    // ------------------------------------------------------------------

    logic signed [EFF_BITS-1:0] eff_s;
    logic                       pass_s;
    logic [PIXEL_BITS-1:0]      shaped_s;

    logic                   wren_q,    wren_d;
    logic [WIDTH_BITS-1:0]  res_col_q, res_col_d;
    logic [HEIGHT_BITS-1:0] res_row_q, res_row_d;
    logic [PIXEL_BITS-1:0]  data_q,    data_d;
    logic                   bit_q,     bit_d;

    // Compare the pixel with the offset threshold and shape it by mode.
    always_comb begin
        eff_s  = eff_threshold(iThresholdData, c_q);
        pass_s = pixel_passes(iImageData, eff_s);
        case (mode_q)
            MODE_BINARY:   shaped_s = pass_s ? {PIXEL_BITS{1'b1}} : {PIXEL_BITS{1'b0}};
            MODE_INVERTED: shaped_s = pass_s ? {PIXEL_BITS{1'b0}} : {PIXEL_BITS{1'b1}};
            MODE_TOZERO:   shaped_s = pass_s ? iImageData : {PIXEL_BITS{1'b0}};
            MODE_TRUNCATE: shaped_s = pass_s ? clamp_pixel(eff_s) : iImageData;
            default:       shaped_s = {PIXEL_BITS{1'b0}};
        endcase

        wren_d    = valid1_q;
        res_col_d = col1_q;
        res_row_d = row1_q;
        // Data and bit keep the last written value between frames.
        if (valid1_q) begin
            data_d = shaped_s;
            bit_d  = pass_s;
        end else begin
            data_d = data_q;
            bit_d  = bit_q;
        end
    end

    // Result registers driving the result-memory write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wren_q    <= 1'b0;
            res_col_q <= {WIDTH_BITS{1'b0}};
            res_row_q <= {HEIGHT_BITS{1'b0}};
            data_q    <= {PIXEL_BITS{1'b0}};
            bit_q     <= 1'b0;
        end else begin
            wren_q    <= wren_d;
            res_col_q <= res_col_d;
            res_row_q <= res_row_d;
            data_q    <= data_d;
            bit_q     <= bit_d;
        end
    end

    assign oReadCol    = col_q;
    assign oReadRow    = row_q;
    assign oResultCol  = res_col_q;
    assign oResultRow  = res_row_q;
    assign oResultData = data_q;
    assign oResultBit  = bit_q;
    assign oResultWren = wren_q;
    assign busy        = busy_q;
    assign finished    = finished_q;

endmodule

// File: tb/tb_threshold_pipe.sv
// Testbench for threshold_pipe on a 4x4 image.
// ROM models with one-cycle registered read feed the DUT; each started frame
// pushes its expected write sequence (col, row, data, bit, edge) into a
// scoreboard queue and an independent monitor pops and compares every write.

module tb_threshold_pipe;

    localparam int WB = 2;
    localparam int HB = 2;
    localparam int PB = 8;
    localparam int CB = 6;
    localparam int W  = 1 << WB;
    localparam int H  = 1 << HB;
    localparam int N  = W * H;
    localparam int PMAX = (1 << PB) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          iStart;
    logic [1:0]    iMode;
    logic [CB-1:0] iC;
    logic [WB-1:0] oReadCol;
    logic [HB-1:0] oReadRow;
    logic [PB-1:0] iImageData;
    logic [PB-1:0] iThresholdData;
    logic [WB-1:0] oResultCol;
    logic [HB-1:0] oResultRow;
    logic [PB-1:0] oResultData;
    logic          oResultBit;
    logic          oResultWren;
    logic          busy;
    logic          finished;

    threshold_pipe #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB),
        .PIXEL_BITS (PB),
        .C_BITS     (CB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iStart        (iStart),
        .iMode         (iMode),
        .iC            (iC),
        .oReadCol      (oReadCol),
        .oReadRow      (oReadRow),
        .iImageData    (iImageData),
        .iThresholdData(iThresholdData),
        .oResultCol    (oResultCol),
        .oResultRow    (oResultRow),
        .oResultData   (oResultData),
        .oResultBit    (oResultBit),
        .oResultWren   (oResultWren),
        .busy          (busy),
        .finished      (finished)
    );

    always #5 clock = ~clock;

    // Rising-edge counter used to time-stamp expectations.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Image and threshold ROMs, one-cycle registered read.
    logic [PB-1:0] img_mem [N];
    logic [PB-1:0] thr_mem [N];
    always @(posedge clock) begin
        iImageData     <= img_mem[{oReadRow, oReadCol}];
        iThresholdData <= thr_mem[{oReadRow, oReadCol}];
    end

    typedef struct {
        int col;
        int row;
        int data;
        int bitv;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   run_len = 0;

    // Reference: threshold rules in plain integer arithmetic.
    function automatic void ref_pixel(input int pix, input int thr, input int mode,
                                      input int c, output int data, output int b);
        int eff;
        int cl;
        eff = thr - c;
        b   = (pix > eff) ? 1 : 0;
        cl  = (eff < 0) ? 0 : ((eff > PMAX) ? PMAX : eff);
        case (mode)
            0:       data = b ? PMAX : 0;
            1:       data = b ? 0 : PMAX;
            2:       data = b ? pix : 0;
            default: data = b ? cl : pix;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare on every write; check write-burst length.
    always @(negedge clock) begin
        if (reset) begin
            run_len = 0;
        end else if (oResultWren === 1'b1) begin
            run_len++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_wren: got write col=%0d row=%0d data=%0d, expected none",
                         oResultCol, oResultRow, oResultData);
            end else begin
                mon_e = exp_q.pop_front();
                if (oResultCol !== WB'(mon_e.col) || oResultRow !== HB'(mon_e.row) ||
                    oResultData !== PB'(mon_e.data) || oResultBit !== 1'(mon_e.bitv) ||
                    cyc != mon_e.edge_no) begin
                    n_err++;
                    $display("FAIL result: got col=%0d row=%0d data=%0d bit=%0d edge=%0d, expected col=%0d row=%0d data=%0d bit=%0d edge=%0d",
                             oResultCol, oResultRow, oResultData, oResultBit, cyc,
                             mon_e.col, mon_e.row, mon_e.data, mon_e.bitv, mon_e.edge_no);
                end
            end
        end else if (run_len != 0) begin
            n_cmp++;
            if (run_len != N) begin
                n_err++;
                $display("FAIL wren_burst: got %0d consecutive writes, expected %0d", run_len, N);
            end
            run_len = 0;
        end
    end

    // pattern 0: ramp vs 120; 1: random vs 250; 2: random vs 10; 3: random both
    task automatic fill_roms(input int pattern);
        for (int i = 0; i < N; i++) begin
            case (pattern)
                0: begin img_mem[i] = PB'(i * 16);   thr_mem[i] = 8'd120; end
                1: begin img_mem[i] = PB'($urandom); thr_mem[i] = 8'd250; end
                2: begin img_mem[i] = PB'($urandom); thr_mem[i] = 8'd10;  end
                default: begin img_mem[i] = PB'($urandom); thr_mem[i] = PB'($urandom); end
            endcase
        end
    endtask

    task automatic push_frame(input int mode, input int c, input int k);
        int d;
        int b;
        for (int p = 0; p < N; p++) begin
            ref_pixel(int'(img_mem[p]), int'(thr_mem[p]), mode, c, d, b);
            exp_q.push_back('{col: p % W, row: p / W, data: d, bitv: b, edge_no: k + p + 2});
        end
    endtask

    // Pulse iStart for one edge; scrambles mode/C afterwards to prove latching.
    task automatic do_start(input int mode, input int c, output int k);
        @(negedge clock);
        iStart = 1'b1;
        iMode  = mode[1:0];
        iC     = c[CB-1:0];
        @(posedge clock);
        #1;
        iStart = 1'b0;
        iMode  = 2'($urandom);
        iC     = CB'($urandom);
        k = cyc;
        check("busy_rise", busy, 1);
        check("finished_clear", finished, 0);
        check("read_addr_start", {oReadRow, oReadCol}, 0);
    endtask

    task automatic run_frame(input int pattern, input int mode, input int c, input bit mid_pulse);
        int k;
        int waited;
        int busy_bad;
        fill_roms(pattern);
        do_start(mode, c, k);
        push_frame(mode, c, k);
        waited   = 0;
        busy_bad = 0;
        while (waited < N + 10) begin
            @(posedge clock);
            #1;
            waited++;
            if (mid_pulse && waited == 4) begin
                iStart = 1'b1;
                iMode  = ~mode[1:0];
                iC     = CB'($urandom);
            end else begin
                iStart = 1'b0;
            end
            if (finished === 1'b1) break;
            if (busy !== 1'b1) busy_bad++;
        end
        iStart = 1'b0;
        check("finish_edge", cyc - k, N + 2);
        check("busy_held", busy_bad, 0);
        check("busy_fall", busy, 0);
        check("wren_fall", oResultWren, 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int k;
        reset  = 1'b1;
        iStart = 1'b0;
        iMode  = 2'd0;
        iC     = '0;
        fill_roms(0);
        #1;
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_wren", oResultWren, 0);
        check("rst_read_addr", {oReadRow, oReadCol}, 0);
        check("rst_result_addr", {oResultRow, oResultCol}, 0);
        check("rst_result_data", {oResultBit, oResultData}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_wren", oResultWren, 0);

        // Directed frames: ramp image against a flat threshold, all modes.
        run_frame(0, 0, 2, 1'b0);
        run_frame(0, 1, 2, 1'b1);
        run_frame(0, 2, 2, 1'b0);
        run_frame(0, 3, 2, 1'b1);
        // Threshold extremes driven by C.
        run_frame(1, 0, -32, 1'b0);
        run_frame(2, 3, 31, 1'b0);
        run_frame(2, 0, 31, 1'b0);

        // Reset while pixel 7 is being addressed.
        fill_roms(0);
        do_start(0, 2, k);
        push_frame(0, 2, k);
        while (cyc < k + 7) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_wren", oResultWren, 0);
        check("midrst_read_addr", {oReadRow, oReadCol}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result_addr", {oResultRow, oResultCol}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("post_rst_idle", busy, 0);
        run_frame(0, 0, 2, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            run_frame(3, int'($urandom_range(0, 3)), int'($urandom_range(0, 63)) - 32, 1'(f % 2));
        end

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/threshold_pipe.md
# threshold_pipe

Parametrised adaptive-threshold engine, successor to the fixed 8-bit binary `threshold` stage. It raster-scans the image ROM and threshold (local-mean) ROM in lock-step, at one pixel per clock. For each pixel it applies one of four selectable threshold modes with a signed offset C, and streams the results to the result memory with a write enable. It sits after the box filter: the top-level sequencer pulses `iStart` once the threshold memory is complete and waits for `finished`.

## Interface
Parameters:
- `WIDTH_BITS`, 8, column address width; image width = 2^WIDTH_BITS
- `HEIGHT_BITS`, 8, row address width; image height = 2^HEIGHT_BITS
- `PIXEL_BITS`, 8, width of pixel, threshold and result data
- `C_BITS`, 6, width of signed two's-complement offset C

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `iStart`  in  1  start request, sampled in IDLE/DONE only
- `iMode`  in  2  0 binary, 1 inverted binary, 2 to-zero, 3 truncate; latched at start
- `iC`  in  C_BITS  signed offset; latched at start
- `oReadCol`  out  WIDTH_BITS  column address, shared by image and threshold ROMs
- `oReadRow`  out  HEIGHT_BITS  row address, shared by both ROMs
- `iImageData`  in  PIXEL_BITS  image ROM data, 1-cycle registered-read latency
- `iThresholdData`  in  PIXEL_BITS  threshold ROM data, same latency
- `oResultCol`  out  WIDTH_BITS  column of the current result
- `oResultRow`  out  HEIGHT_BITS  row of the current result
- `oResultData`  out  PIXEL_BITS  result value
- `oResultBit`  out  1  raw comparison, pixel > effective threshold
- `oResultWren`  out  1  result write strobe, one cycle per pixel
- `busy`  out  1  high in RUN and DRAIN
- `finished`  out  1  level, high in DONE

## Operation
- States:
  - IDLE -> RUN on `iStart`.
  - RUN -> DRAIN after address (W-1,H-1) has been issued.
  - DRAIN (2 cycles) -> DONE.
  - DONE -> RUN on `iStart`; DONE holds otherwise.
- `iStart` in RUN or DRAIN is ignored. Mode and C are frozen for the whole frame.
- Scan order is raster: column increments fastest; the column wraps to 0 and the row increments at W-1.
- The address counters reset to 0 when entering RUN. They hold their last value outside RUN.
- Arithmetic:
  - eff = thr − C, computed signed in PIXEL_BITS+C_BITS+1 bits; there is no wrap.
  - bit = (pixel > eff), strict compare with pixel zero-extended.
- Result data by mode:
  - binary: all-ones if bit, else 0.
  - inverted: all-ones if !bit, else 0.
  - to-zero: pixel if bit, else 0.
  - truncate: clamp(eff, 0, 2^PIXEL_BITS−1) if bit, else pixel.
- Result col/row are the read address delayed 2 cycles, so they always match the data.
- Reset values: state IDLE; all address, result, `oResultWren`, `busy` and `finished` outputs are 0.

## Timing
- Start at edge k means `iStart` is sampled high at edge k.
- Address p (0-based, raster index) is driven from edge k+p.
- ROM data for p arrives after edge k+p+1.
- `oResultWren` and the data for p are valid in the cycle after edge k+p+2. Latency is 2 cycles.
- Throughput is 1 pixel per clock with no gaps. With N = W·H pixels, `oResultWren` is high for exactly N consecutive cycles.
- `busy` rises at edge k. `busy` falls, `finished` rises and `oResultWren` falls, all at edge k+N+2.
- Restarting from DONE at edge j clears `finished` at edge j. It uses the same timing as above.
- `reset` asserted mid-frame: all outputs return to reset values immediately (asynchronously), and no further writes occur. The next start begins at (0,0).
- Boundaries:
  - Large C where thr−C < 0 makes every pixel pass (`bit`=1).
  - Negative C where thr−C ≥ 2^PIXEL_BITS makes every pixel fail.
  - A single-pixel image (both *_BITS=0) is not supported; the minimum is 1.

## Test plan
- WIDTH_BITS=HEIGHT_BITS=2 (N=16), mode 0, C=2, image=i·16, threshold=120. Required: 16 consecutive wrens at k+2..k+17; bit=1 exactly where i·16>118 (i≥8); `finished` rises at k+18.
- Same data, mode 1. Required: outputs are the complement of the previous run. Mode 2 outputs pixel or 0. Mode 3 outputs 118 for i≥8 and pixel otherwise.
- C=−32 with threshold 250: eff=282 > 255, so all results are 0 in mode 0. C=31 with threshold 10: eff=−21, so all bits are 1 and mode 3 outputs 0.
- Address-order check: `oResultCol`/`oResultRow` sequence is (0,0),(1,0)…(3,0),(0,1)…(3,3) and matches the ROM address from 2 cycles earlier.
- `iStart` pulsed mid-RUN changes nothing. A restart from DONE with a new mode produces a second full frame, and `finished` drops at the restart edge.
- `reset` asserted at pixel 7: wren is 0 and addresses are 0 immediately. After release and start, the frame restarts at (0,0) with 16 writes.
